// File: rtl/shiftreg_pkg.sv
// Shared types and helpers for the 74HC595-class serial output driver.
package shiftreg_pkg;

   // Frame sequencing states
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SHIFT_LO = 3'd1,
      SHIFT_HI = 3'd2,
      SETTLE   = 3'd3,
      LATCH    = 3'd4
   } state_t;

   // Bit order selection values for the LSB_FIRST parameter
   typedef enum logic {
      ORDER_MSB_FIRST = 1'b0,
      ORDER_LSB_FIRST = 1'b1
   } order_t;

   // Counter width able to hold values 0..max_val
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/shiftreg_tick.sv
// Phase timer: one-cycle tick every DIV cycles while not cleared.
module shiftreg_tick
   import shiftreg_pkg::*;
#(
   parameter int unsigned DIV = 4
)(
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   output logic o_tick_c
);

   localparam int unsigned   CW   = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   assign o_tick_c = !i_clear && (r_cnt == LAST);

   // Divider counter, wraps to zero at the end of every phase
   always_ff @(posedge clk) begin
      if (rst || i_clear || o_tick_c) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/shiftreg_out.sv
// Serial frame driver for daisy-chained 74HC595-class shift registers.
// Optional feature: define SHIFTREG_OUT_OE_EN to add the active-low
// output-enable port shift_oe_n.
module shiftreg_out
   import shiftreg_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHAINS    = 2,
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned LSB_FIRST = 0
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [WIDTH*CHAINS-1:0] load_data,
   input  logic                    load_valid,
   output logic                    load_ready,
   output logic                    shift_clock,
   output logic                    shift_data,
   output logic                    shift_latch,
   output logic                    busy,
   output logic                    done
`ifdef SHIFTREG_OUT_OE_EN
   ,
   output logic                    shift_oe_n
`endif
);

   localparam int unsigned   N        = WIDTH * CHAINS;
   localparam int unsigned   BW       = cnt_width(N);
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
   localparam bit            LSB_MODE = (LSB_FIRST == 32'(ORDER_LSB_FIRST));

   state_t         r_state;
   state_t         w_state_nxt;
   logic [N-1:0]   r_shreg;
   logic [N-1:0]   w_shreg_nxt;
   logic [BW-1:0]  r_bit_cnt;
   logic [BW-1:0]  w_bit_cnt_nxt;
   logic           w_tick;
   logic           w_accept;
   logic           w_last_bit;

   logic           r_shift_clock;
   logic           r_shift_data;
   logic           r_shift_latch;
   logic           r_load_ready;
   logic           r_busy;
   logic           r_done;
   logic           w_shift_clock_nxt;
   logic           w_shift_data_nxt;
   logic           w_shift_latch_nxt;
   logic           w_load_ready_nxt;
   logic           w_done_nxt;

   assign w_accept   = (r_state == IDLE) && load_valid;
   assign w_last_bit = (r_bit_cnt == LAST_BIT);

   shiftreg_tick #(
      .DIV      (CLK_DIV)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (r_state == IDLE),
      .o_tick_c (w_tick)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: each timed state advances on the phase tick
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (load_valid) w_state_nxt = SHIFT_LO;
         SHIFT_LO: if (w_tick)     w_state_nxt = SHIFT_HI;
         SHIFT_HI: if (w_tick)     w_state_nxt = w_last_bit ? SETTLE : SHIFT_LO;
         SETTLE:   if (w_tick)     w_state_nxt = LATCH;
         LATCH:    if (w_tick)     w_state_nxt = IDLE;
         default:                  w_state_nxt = IDLE;
      endcase
   end

   // Frame register and bit counter update; shift happens as a bit's high phase ends
   always_comb begin
      w_shreg_nxt   = r_shreg;
      w_bit_cnt_nxt = r_bit_cnt;
      if (w_accept) begin
         w_shreg_nxt   = load_data;
         w_bit_cnt_nxt = '0;
      end else if ((r_state == SHIFT_HI) && w_tick) begin
         w_shreg_nxt   = LSB_MODE ? (r_shreg >> 1) : (r_shreg << 1);
         w_bit_cnt_nxt = w_last_bit ? '0 : r_bit_cnt + BW'(1);
      end
   end

   // Output decode from the upcoming state so every port is a flop
   always_comb begin
      w_shift_clock_nxt = 1'b0;
      w_shift_data_nxt  = 1'b0;
      w_shift_latch_nxt = 1'b0;
      w_load_ready_nxt  = 1'b0;
      w_done_nxt        = 1'b0;
      case (w_state_nxt)
         IDLE: begin
            w_load_ready_nxt = 1'b1;
            w_done_nxt       = (r_state == LATCH);
         end
         SHIFT_LO: begin
            w_shift_data_nxt = LSB_MODE ? w_shreg_nxt[0] : w_shreg_nxt[N-1];
         end
         SHIFT_HI: begin
            w_shift_clock_nxt = 1'b1;
            w_shift_data_nxt  = LSB_MODE ? w_shreg_nxt[0] : w_shreg_nxt[N-1];
         end
         LATCH: begin
            w_shift_latch_nxt = 1'b1;
         end
         default: begin
            w_shift_data_nxt = 1'b0;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
      end else begin
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift_clock <= 1'b0;
         r_shift_data  <= 1'b0;
         r_shift_latch <= 1'b0;
         r_load_ready  <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_shift_clock <= w_shift_clock_nxt;
         r_shift_data  <= w_shift_data_nxt;
         r_shift_latch <= w_shift_latch_nxt;
         r_load_ready  <= w_load_ready_nxt;
         r_busy        <= !w_load_ready_nxt;
         r_done        <= w_done_nxt;
      end
   end

   assign shift_clock = r_shift_clock;
   assign shift_data  = r_shift_data;
   assign shift_latch = r_shift_latch;
   assign load_ready  = r_load_ready;
   assign busy        = r_busy;
   assign done        = r_done;

`ifdef SHIFTREG_OUT_OE_EN
   logic r_oe_n;

   // Device outputs stay disabled until the first frame has been latched
   always_ff @(posedge clk) begin
      if (rst) begin
         r_oe_n <= 1'b1;
      end else if (w_done_nxt) begin
         r_oe_n <= 1'b0;
      end
   end

   assign shift_oe_n = r_oe_n;
`endif

endmodule

// File: tb/tb_shiftreg_out.sv
// Self-checking bench for shiftreg_out: two 16-bit instances (MSB/LSB first,
// CLK_DIV=2) sharing stimulus, plus an 8-bit CLK_DIV=1 instance.
module tb_shiftreg_out;

   localparam int unsigned W       = 8;
   localparam int unsigned CH      = 2;
   localparam int unsigned N       = W * CH;
   localparam int unsigned D       = 2;
   localparam int unsigned NC      = 8;
   localparam int unsigned DC      = 1;
   localparam int          FRAME   = (2 * N + 2) * D;
   localparam int          FRAME_C = (2 * NC + 2) * DC;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  ab_load_data;
   logic          ab_load_valid;
   logic          a_load_ready, a_shift_clock, a_shift_data, a_shift_latch, a_busy, a_done;
   logic          b_load_ready, b_shift_clock, b_shift_data, b_shift_latch, b_busy, b_done;
   logic [NC-1:0] c_load_data;
   logic          c_load_valid;
   logic          c_load_ready, c_shift_clock, c_shift_data, c_shift_latch, c_busy, c_done;
`ifdef SHIFTREG_OUT_OE_EN
   logic          a_shift_oe_n, b_shift_oe_n, c_shift_oe_n;
   bit            oe_low_ab = 1'b0;
   bit            oe_low_c  = 1'b0;
`endif

   int checks       = 0;
   int failures     = 0;
   int cyc          = 0;
   int ab_done_seen = 0;

   always #5 clk = ~clk;

   shiftreg_out #(.WIDTH(W), .CHAINS(CH), .CLK_DIV(D), .LSB_FIRST(0)) u_dut_a (
      .clk(clk), .rst(rst), .load_data(ab_load_data), .load_valid(ab_load_valid),
      .load_ready(a_load_ready), .shift_clock(a_shift_clock), .shift_data(a_shift_data),
      .shift_latch(a_shift_latch), .busy(a_busy), .done(a_done)
`ifdef SHIFTREG_OUT_OE_EN
      , .shift_oe_n(a_shift_oe_n)
`endif
   );

   shiftreg_out #(.WIDTH(W), .CHAINS(CH), .CLK_DIV(D), .LSB_FIRST(1)) u_dut_b (
      .clk(clk), .rst(rst), .load_data(ab_load_data), .load_valid(ab_load_valid),
      .load_ready(b_load_ready), .shift_clock(b_shift_clock), .shift_data(b_shift_data),
      .shift_latch(b_shift_latch), .busy(b_busy), .done(b_done)
`ifdef SHIFTREG_OUT_OE_EN
      , .shift_oe_n(b_shift_oe_n)
`endif
   );

   shiftreg_out #(.WIDTH(8), .CHAINS(1), .CLK_DIV(DC), .LSB_FIRST(0)) u_dut_c (
      .clk(clk), .rst(rst), .load_data(c_load_data), .load_valid(c_load_valid),
      .load_ready(c_load_ready), .shift_clock(c_shift_clock), .shift_data(c_shift_data),
      .shift_latch(c_shift_latch), .busy(c_busy), .done(c_done)
`ifdef SHIFTREG_OUT_OE_EN
      , .shift_oe_n(c_shift_oe_n)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Order in which bits reach the device: first bit ends up at position len-1
   function automatic logic [N-1:0] ref_seq(input logic [N-1:0] d, input int len, input bit lsb);
      logic [N-1:0] s;
      s = '0;
      for (int i = 0; i < len; i++) s[len-1-i] = lsb ? d[i] : d[len-1-i];
      return s;
   endfunction

   // Expected port levels at cycle c after the accept edge
   function automatic void ref_wave(input int c, input int n, input int div,
                                    output bit sclk, output bit latch, output bit bsy,
                                    output bit dn, output bit dzero);
      int total;
      total = (2 * n + 2) * div;
      bsy   = (c >= 1) && (c <= total);
      dn    = (c == total + 1);
      sclk  = (c >= 1) && (c <= 2 * n * div) && ((((c - 1) / div) % 2) == 1);
      latch = (c > (2 * n + 1) * div) && (c <= total);
      dzero = (c > 2 * n * div);
   endfunction

   task automatic run_frame_ab(input logic [N-1:0] d, input bit hold, input logic [N-1:0] next_d,
                               input string tag, output int waited);
      logic [N-1:0] seq_a, seq_b, exp_a, exp_b;
      int  rises_a, rises_b, bad;
      bit  pa_clk, pa_dat, pb_clk, pb_dat;
      bit  e_clk, e_lat, e_busy, e_done, e_dz;
      seq_a = '0; seq_b = '0; rises_a = 0; rises_b = 0; bad = 0;
      pa_clk = 1'b0; pa_dat = 1'b0; pb_clk = 1'b0; pb_dat = 1'b0;
      ab_load_valid = 1'b1;
      ab_load_data  = d;
      waited = 0;
      while (!a_load_ready && waited < 200) begin step(); waited++; end
      if (!a_load_ready) begin
         checks++; failures++;
         $display("FAIL %s ready_timeout got=%0b exp=1", tag, a_load_ready);
         ab_load_valid = 1'b0;
         return;
      end
      cyc = 0;
      step();
      if (hold) begin
         ab_load_data = next_d;
      end else begin
         ab_load_valid = 1'b0;
         ab_load_data  = N'($urandom);
      end
      for (int k = 1; k <= FRAME + 1; k++) begin
         if (k != 1) step();
         ref_wave(cyc, N, D, e_clk, e_lat, e_busy, e_done, e_dz);
         if (a_shift_clock && !pa_clk) begin seq_a = {seq_a[N-2:0], a_shift_data}; rises_a++; end
         if (b_shift_clock && !pb_clk) begin seq_b = {seq_b[N-2:0], b_shift_data}; rises_b++; end
         if (pa_clk && a_shift_clock && (a_shift_data !== pa_dat)) bad++;
         if (pb_clk && b_shift_clock && (b_shift_data !== pb_dat)) bad++;
         if (a_shift_clock !== e_clk || a_shift_latch !== e_lat || a_busy !== e_busy ||
             a_load_ready !== !e_busy || a_done !== e_done) bad++;
         if (b_shift_clock !== e_clk || b_shift_latch !== e_lat || b_busy !== e_busy ||
             b_load_ready !== !e_busy || b_done !== e_done) bad++;
         if (e_dz && (a_shift_data !== 1'b0 || b_shift_data !== 1'b0)) bad++;
`ifdef SHIFTREG_OUT_OE_EN
         if (a_shift_oe_n !== !(oe_low_ab || e_done)) bad++;
         if (b_shift_oe_n !== !(oe_low_ab || e_done)) bad++;
`endif
         if (a_done) ab_done_seen++;
         pa_clk = a_shift_clock; pa_dat = a_shift_data;
         pb_clk = b_shift_clock; pb_dat = b_shift_data;
      end
`ifdef SHIFTREG_OUT_OE_EN
      oe_low_ab = 1'b1;
`endif
      exp_a = ref_seq(d, N, 1'b0);
      exp_b = ref_seq(d, N, 1'b1);
      checks++;
      if (seq_a !== exp_a) begin failures++; $display("FAIL %s msb_seq got=%b exp=%b", tag, seq_a, exp_a); end
      checks++;
      if (seq_b !== exp_b) begin failures++; $display("FAIL %s lsb_seq got=%b exp=%b", tag, seq_b, exp_b); end
      checks++;
      if (rises_a != N) begin failures++; $display("FAIL %s msb_rises got=%0d exp=%0d", tag, rises_a, N); end
      checks++;
      if (rises_b != N) begin failures++; $display("FAIL %s lsb_rises got=%0d exp=%0d", tag, rises_b, N); end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL %s waveform bad_cycles=%0d exp=0", tag, bad); end
   endtask

   task automatic run_frame_c(input logic [NC-1:0] d, input string tag);
      logic [N-1:0] seq, exp_s;
      int  rises, bad, waited;
      bit  p_clk, p_dat, e_clk, e_lat, e_busy, e_done, e_dz;
      seq = '0; rises = 0; bad = 0; waited = 0; p_clk = 1'b0; p_dat = 1'b0;
      c_load_valid = 1'b1;
      c_load_data  = d;
      while (!c_load_ready && waited < 100) begin step(); waited++; end
      if (!c_load_ready) begin
         checks++; failures++;
         $display("FAIL %s c_ready_timeout got=%0b exp=1", tag, c_load_ready);
         c_load_valid = 1'b0;
         return;
      end
      cyc = 0;
      step();
      c_load_valid = 1'b0;
      c_load_data  = NC'($urandom);
      for (int k = 1; k <= FRAME_C + 1; k++) begin
         if (k != 1) step();
         ref_wave(cyc, NC, DC, e_clk, e_lat, e_busy, e_done, e_dz);
         if (c_shift_clock && !p_clk) begin seq = {seq[N-2:0], c_shift_data}; rises++; end
         if (p_clk && c_shift_clock && (c_shift_data !== p_dat)) bad++;
         if (c_shift_clock !== e_clk || c_shift_latch !== e_lat || c_busy !== e_busy ||
             c_load_ready !== !e_busy || c_done !== e_done) bad++;
         if (e_dz && c_shift_data !== 1'b0) bad++;
`ifdef SHIFTREG_OUT_OE_EN
         if (c_shift_oe_n !== !(oe_low_c || e_done)) bad++;
`endif
         p_clk = c_shift_clock; p_dat = c_shift_data;
      end
`ifdef SHIFTREG_OUT_OE_EN
      oe_low_c = 1'b1;
`endif
      exp_s = ref_seq(N'(d), NC, 1'b0);
      checks++;
      if (seq !== exp_s) begin failures++; $display("FAIL %s c_seq got=%b exp=%b", tag, seq[NC-1:0], exp_s[NC-1:0]); end
      checks++;
      if (rises != NC) begin failures++; $display("FAIL %s c_rises got=%0d exp=%0d", tag, rises, NC); end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL %s c_waveform bad_cycles=%0d exp=0", tag, bad); end
   endtask

   task automatic test_reset();
      logic [5:0] va, vb, vc;
      rst = 1'b1;
      step();
      step();
      va = {a_shift_clock, a_shift_data, a_shift_latch, a_busy, a_done, a_load_ready};
      vb = {b_shift_clock, b_shift_data, b_shift_latch, b_busy, b_done, b_load_ready};
      vc = {c_shift_clock, c_shift_data, c_shift_latch, c_busy, c_done, c_load_ready};
      checks++;
      if (va !== 6'b000001) begin failures++; $display("FAIL reset_a got=%b exp=000001", va); end
      checks++;
      if (vb !== 6'b000001) begin failures++; $display("FAIL reset_b got=%b exp=000001", vb); end
      checks++;
      if (vc !== 6'b000001) begin failures++; $display("FAIL reset_c got=%b exp=000001", vc); end
`ifdef SHIFTREG_OUT_OE_EN
      checks++;
      if (a_shift_oe_n !== 1'b1) begin failures++; $display("FAIL reset_oe got=%b exp=1", a_shift_oe_n); end
      oe_low_ab = 1'b0;
      oe_low_c  = 1'b0;
`endif
      rst = 1'b0;
      step();
   endtask

   task automatic test_a5c3();
      int w;
      run_frame_ab(16'hA5C3, 1'b0, '0, "a5c3", w);
   endtask

   task automatic test_random();
      int w;
      for (int i = 0; i < 6; i++) begin
         run_frame_ab(N'($urandom), 1'b0, '0, $sformatf("rand%0d", i), w);
         repeat ($urandom_range(0, 3)) step();
      end
   endtask

   task automatic test_back_to_back();
      int w1, w2, done_before;
      done_before = ab_done_seen;
      run_frame_ab(N'($urandom), 1'b1, 16'h00FF, "b2b_f1", w1);
      run_frame_ab(16'h00FF, 1'b0, '0, "b2b_f2", w2);
      checks++;
      if (w2 != 0) begin failures++; $display("FAIL b2b_gap got=%0d exp=0", w2); end
      checks++;
      if (ab_done_seen - done_before != 2) begin
         failures++;
         $display("FAIL b2b_done_pulses got=%0d exp=2", ab_done_seen - done_before);
      end
   endtask

   task automatic test_mid_reset();
      logic [5:0] va, vb;
      int bad, w;
      ab_load_valid = 1'b1;
      ab_load_data  = N'($urandom);
      cyc = 0;
      step();
      ab_load_valid = 1'b0;
      while (cyc < 20) step();
      rst = 1'b1;
      step();
      va = {a_shift_clock, a_shift_data, a_shift_latch, a_busy, a_done, a_load_ready};
      vb = {b_shift_clock, b_shift_data, b_shift_latch, b_busy, b_done, b_load_ready};
      checks++;
      if (va !== 6'b000001) begin failures++; $display("FAIL midreset_a got=%b exp=000001", va); end
      checks++;
      if (vb !== 6'b000001) begin failures++; $display("FAIL midreset_b got=%b exp=000001", vb); end
`ifdef SHIFTREG_OUT_OE_EN
      checks++;
      if (a_shift_oe_n !== 1'b1) begin failures++; $display("FAIL midreset_oe got=%b exp=1", a_shift_oe_n); end
      oe_low_ab = 1'b0;
      oe_low_c  = 1'b0;
`endif
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < FRAME + 10; k++) begin
         step();
         if (a_shift_latch || a_done || !a_load_ready || b_shift_latch || b_done || !b_load_ready) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL midreset_abandon bad_cycles=%0d exp=0", bad); end
      run_frame_ab(N'($urandom), 1'b0, '0, "after_reset", w);
   endtask

   task automatic test_fast();
      run_frame_c(8'h01, "fast01");
      for (int i = 0; i < 3; i++) run_frame_c(NC'($urandom), $sformatf("fast_rand%0d", i));
   endtask

   initial begin
      rst           = 1'b1;
      ab_load_valid = 1'b0;
      ab_load_data  = '0;
      c_load_valid  = 1'b0;
      c_load_data   = '0;
      test_reset();
      test_a5c3();
      test_random();
      test_back_to_back();
      test_mid_reset();
      test_fast();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/shiftreg_out.md
SHIFTREG_OUT -- requirements
Module: shiftreg_out

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per 74HC595-class device.
REQ-002 SHALL have parameter CHAINS, default 2: number of daisy-chained devices; frame length N = WIDTH*CHAINS.
REQ-003 SHALL have parameter CLK_DIV, default 4: clk cycles per half shift_clock period; legal range >= 1.
REQ-004 SHALL have parameter LSB_FIRST, default 0: 0 shifts bit N-1 first, 1 shifts bit 0 first.
REQ-005 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port load_data, input, N: frame to shift out.
REQ-008 SHALL have port load_valid, input, 1: frame offered.
REQ-009 SHALL have port load_ready, output, 1: block can accept a frame.
REQ-010 SHALL have port shift_clock, output, 1: serial clock; device samples on rising edge.
REQ-011 SHALL have port shift_data, output, 1: serial data.
REQ-012 SHALL have port shift_latch, output, 1: storage-register latch pulse.
REQ-013 SHALL have port busy, output, 1: frame in progress.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at frame completion.

Function
REQ-015 SHALL accept a frame on a clk edge where load_valid && load_ready, registering load_data internally (accept edge = cycle 0).
REQ-016 SHALL use FSM states IDLE -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO for next bit | SETTLE after last bit) -> LATCH -> IDLE.
REQ-017 SHALL present bit k on shift_data from the first SHIFT_LO cycle of bit k until the last SHIFT_HI cycle of bit k; shift_data does not change while shift_clock is high.
REQ-018 SHALL hold SHIFT_LO (shift_clock=0) and SHIFT_HI (shift_clock=1) each for exactly CLK_DIV cycles per bit.
REQ-019 SHALL hold SETTLE (shift_clock=0, shift_latch=0) for CLK_DIV cycles, then LATCH (shift_latch=1) for CLK_DIV cycles.
REQ-020 SHALL total exactly (2*N+2)*CLK_DIV cycles from cycle 1 to last LATCH cycle; IDLE entered at cycle (2*N+2)*CLK_DIV+1.
REQ-021 SHALL assert load_ready only in IDLE; busy = !load_ready.
REQ-022 SHALL pulse done for exactly the first IDLE cycle after LATCH; load_ready is also 1 in that cycle, permitting back-to-back frames with no extra gap.
REQ-023 SHALL ignore load_valid and load_data while busy; in-flight frame unaffected by load_data changes.
REQ-024 SHALL use a divider counter of width $clog2(CLK_DIV+1) and a bit counter of width $clog2(N+1); counters wrap to 0 at phase/bit end with no overflow.
REQ-025 SHALL drive shift_data = 0 in IDLE, SETTLE and LATCH.

Reset
REQ-026 SHALL, on rst, set state IDLE, shift_clock=0, shift_data=0, shift_latch=0, busy=0, done=0, load_ready=1 in the following cycle.
REQ-027 SHALL abandon any frame on reset mid-operation: no latch pulse, no done pulse; rst has priority over load_valid.

Configuration
REQ-028 SHALL, with SHIFTREG_OUT_OE_EN defined, add output shift_oe_n (1 bit, active-low device output enable), held 1 from reset until the end of the first completed LATCH, then 0 until next reset.
REQ-029 SHALL, without SHIFTREG_OUT_OE_EN, omit shift_oe_n entirely; all other behaviour identical.

Structure
REQ-030 SHALL place the FSM state enum and LSB/MSB-first order constants in shared package shiftreg_pkg.
REQ-031 SHALL implement the CLK_DIV phase counter as sub-module shiftreg_tick (outputs one-cycle phase-end tick; synchronous clear input).

Verification
REQ-032 WIDTH=8, CHAINS=2, CLK_DIV=2, LSB_FIRST=0, load 16'hA5C3 -> 16 shift_clock rising edges sampling 1010010111000011; latch high cycles 67-68; done=1 at cycle 69.
REQ-033 Same with LSB_FIRST=1 -> sampled sequence 1100001110100101.
REQ-034 Second load_valid held high with 16'h00FF through frame 1 -> not accepted until cycle 69; frame 2 starts cycle 70; exactly two done pulses.
REQ-035 rst asserted at cycle 20 of a frame -> next cycle all outputs at reset values, no shift_latch pulse, no done; new load then completes normally.
REQ-036 CLK_DIV=1, CHAINS=1, load 8'h01 -> frame in 18 cycles, shift_clock period 2 cycles, last sampled bit 1.
REQ-037 With SHIFTREG_OUT_OE_EN: shift_oe_n=1 after reset, falls at end of first latch, stays 0 through later frames.
